eth_tx_scheduler: RTL and testbench



---
 rtl/eth_tx_pkg.sv | 32 +++
 rtl/eth_tx_scheduler_rr_arbiter.sv | 53 +++++
 rtl/eth_tx_scheduler.sv | 175 +++++++++++++++++
 tb/tb_eth_tx_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types, constants and width helpers for the Ethernet TX scheduling path.
`default_nettype none

package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARB      = 3'd1,
        ANNOUNCE = 3'd2,
        STREAM   = 3'd3,
        FLUSH    = 3'd4,
        WAIT_TX  = 3'd5,
        IFG      = 3'd6
    } tx_state_e;

    localparam int IFG_BYTES   = 12;
    localparam int MAX_PAYLOAD = 1500;
    localparam int MIN_PAYLOAD = 46;

    // Index width for an n-entry vector; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/eth_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches upward from the last winner, wrapping; the pointer
// advances only on an explicit update strobe so grants stay stable while idle.
`default_nettype none

module rr_arbiter
    import eth_tx_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC-1:0]               req,
    input  logic                             update,
    output logic [NUM_SRC-1:0]               grant,
    output logic [idx_width(NUM_SRC)-1:0]    grant_idx,
    output logic                             grant_any
);

    localparam int IDX_W = idx_width(NUM_SRC);

    logic [IDX_W-1:0] r_ptr;

    always_comb begin
        int cand;
        cand      = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // Walk from farthest to nearest so the nearest requester after r_ptr wins.
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = int'(r_ptr) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (req[cand]) begin
                grant     = NUM_SRC'(1) << cand;
                grant_idx = IDX_W'(cand);
                grant_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= IDX_W'(NUM_SRC - 1);
        end else if (update && grant_any) begin
            r_ptr <= grant_idx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/eth_tx_scheduler.sv
// Multiplexes NUM_SRC payload FIFOs onto one frame encapsulator: round-robin grant,
// buffer handshake (ready / stream / empty), completion wait and inter-frame gap.
`default_nettype none

module eth_tx_scheduler
    import eth_tx_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int LEN_W        = 11,
    parameter int MAX_LEN      = MAX_PAYLOAD,
    parameter int IFG_CYCLES   = IFG_BYTES,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tx_enable,
    input  logic [NUM_SRC-1:0]               src_req,
    input  logic [NUM_SRC*LEN_W-1:0]         src_len,
    input  logic [NUM_SRC*8-1:0]             src_data,
    output logic [NUM_SRC-1:0]               src_rd,
    output logic [NUM_SRC-1:0]               src_ack,
    output logic                             src_err,
    output logic                             fr_buffer_ready,
    output logic                             fr_read_en,
    output logic [7:0]                       fr_data,
    output logic                             fr_buffer_empt,
    input  logic                             fr_busy,
    output logic                             grant_valid,
    output logic [idx_width(NUM_SRC)-1:0]    grant_id
);

    localparam int IDX_W = idx_width(NUM_SRC);
    localparam int TO_W  = cnt_width(BUSY_TIMEOUT);
    localparam int IFG_W = cnt_width(IFG_CYCLES);

    localparam logic [LEN_W:0]   c_max_len  = (LEN_W + 1)'(MAX_LEN);
    localparam logic [TO_W-1:0]  c_to_last  = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [IFG_W-1:0] c_ifg_last = IFG_W'(IFG_CYCLES - 1);

    tx_state_e          r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_byte_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [IFG_W-1:0]   r_ifg_cnt;
    logic [NUM_SRC-1:0] r_gnt_oh;

    logic [NUM_SRC-1:0] w_arb_grant;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_any;
    logic [LEN_W-1:0]   w_arb_len;
    logic               w_len_bad;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (src_req),
        .update    (r_state == ARB),
        .grant     (w_arb_grant),
        .grant_idx (w_arb_idx),
        .grant_any (w_arb_any)
    );

    assign w_arb_len = src_len[int'(w_arb_idx)*LEN_W +: LEN_W];
    assign w_len_bad = (w_arb_len == '0) || ({1'b0, w_arb_len} > c_max_len);

    // Framer sees zero on its data bus whenever it is not being fed.
    assign fr_data = fr_read_en ? src_data[int'(grant_id)*8 +: 8] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_len           <= '0;
            r_byte_cnt      <= '0;
            r_to_cnt        <= '0;
            r_ifg_cnt       <= '0;
            r_gnt_oh        <= '0;
            grant_valid     <= 1'b0;
            grant_id        <= '0;
            src_rd          <= '0;
            src_ack         <= '0;
            src_err         <= 1'b0;
            fr_buffer_ready <= 1'b0;
            fr_read_en      <= 1'b0;
            fr_buffer_empt  <= 1'b0;
        end else begin
            src_ack         <= '0;
            src_err         <= 1'b0;
            fr_buffer_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_enable && (|src_req)) begin
                        r_state <= ARB;
                    end
                end
                ARB: begin
                    if (!w_arb_any) begin
                        r_state <= IDLE;
                    end else begin
                        grant_id <= w_arb_idx;
                        r_len    <= w_arb_len;
                        r_gnt_oh <= w_arb_grant;
                        if (w_len_bad) begin
                            // Rejected frames never touch the framer.
                            src_ack     <= w_arb_grant;
                            src_err     <= 1'b1;
                            grant_valid <= 1'b0;
                            r_ifg_cnt   <= '0;
                            r_state     <= IFG;
                        end else begin
                            grant_valid     <= 1'b1;
                            fr_buffer_ready <= 1'b1;
                            r_state         <= ANNOUNCE;
                        end
                    end
                end
                ANNOUNCE: begin
                    fr_read_en <= 1'b1;
                    src_rd     <= r_gnt_oh;
                    r_byte_cnt <= '0;
                    r_state    <= STREAM;
                end
                STREAM: begin
                    if (r_byte_cnt == r_len - LEN_W'(1)) begin
                        fr_read_en     <= 1'b0;
                        src_rd         <= '0;
                        fr_buffer_empt <= 1'b1;
                        r_to_cnt       <= '0;
                        r_state        <= FLUSH;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + LEN_W'(1);
                    end
                end
                FLUSH: begin
                    if (fr_busy) begin
                        fr_buffer_empt <= 1'b0;
                        r_state        <= WAIT_TX;
                    end else if (r_to_cnt == c_to_last) begin
                        fr_buffer_empt <= 1'b0;
                        src_ack        <= r_gnt_oh;
                        src_err        <= 1'b1;
                        grant_valid    <= 1'b0;
                        r_ifg_cnt      <= '0;
                        r_state        <= IFG;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                WAIT_TX: begin
                    if (!fr_busy) begin
                        src_ack     <= r_gnt_oh;
                        grant_valid <= 1'b0;
                        r_ifg_cnt   <= '0;
                        r_state     <= IFG;
                    end
                end
                IFG: begin
                    // Counter only advances below its terminal value, so it cannot wrap.
                    if (r_ifg_cnt >= c_ifg_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + IFG_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler with FWFT source FIFOs and a simple framer model.
`default_nettype none

module tb_eth_tx_scheduler;

    localparam int NUM_SRC      = 4;
    localparam int LEN_W        = 11;
    localparam int IFG_CYCLES   = 12;
    localparam int BUSY_TIMEOUT = 64;
    localparam int IDX_W        = 2;
    localparam int LOG_N        = 64;

    logic                       clk;
    logic                       rst;
    logic                       tx_enable;
    logic [NUM_SRC-1:0]         src_req;
    logic [NUM_SRC*LEN_W-1:0]   src_len;
    logic [NUM_SRC*8-1:0]       src_data;
    logic [NUM_SRC-1:0]         src_rd;
    logic [NUM_SRC-1:0]         src_ack;
    logic                       src_err;
    logic                       fr_buffer_ready;
    logic                       fr_read_en;
    logic [7:0]                 fr_data;
    logic                       fr_buffer_empt;
    logic                       fr_busy;
    logic                       grant_valid;
    logic [IDX_W-1:0]           grant_id;

    eth_tx_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .LEN_W        (LEN_W),
        .MAX_LEN      (1500),
        .IFG_CYCLES   (IFG_CYCLES),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .tx_enable       (tx_enable),
        .src_req         (src_req),
        .src_len         (src_len),
        .src_data        (src_data),
        .src_rd          (src_rd),
        .src_ack         (src_ack),
        .src_err         (src_err),
        .fr_buffer_ready (fr_buffer_ready),
        .fr_read_en      (fr_read_en),
        .fr_data         (fr_data),
        .fr_buffer_empt  (fr_buffer_empt),
        .fr_busy         (fr_busy),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source model: want[i] frames requested, served[i] acknowledged.
    int               want   [NUM_SRC];
    int               served [NUM_SRC];
    int               pos    [NUM_SRC];
    logic [LEN_W-1:0] len_cfg[NUM_SRC];
    bit               fm_enable;
    int               fm_cnt;

    function automatic logic [7:0] pat(input int i, input int p);
        int v;
        v = i * 37 + p * 3 + 1;
        return v[7:0];
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_req[i]                 = (want[i] > served[i]);
        assign src_len[i*LEN_W +: LEN_W]  = len_cfg[i];
        assign src_data[i*8 +: 8]         = pat(i, pos[i]);
    end

    int cyc, rd_total, ready_total, data_err, excl_err, empt_cyc;
    int acnt, gcnt;
    int ack_id [LOG_N];
    int ack_err[LOG_N];
    int ack_cyc[LOG_N];
    int glog   [LOG_N];
    int gcyc   [LOG_N];
    bit prev_gv, prev_empt;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            fr_busy = 1'b0;
            fm_cnt  = 0;
        end else begin
            if (fm_enable) begin
                if (fr_busy) begin
                    fm_cnt++;
                    if (fm_cnt == 80) begin fr_busy = 1'b0; fm_cnt = 0; end
                end else if (fr_buffer_empt) begin
                    fm_cnt++;
                    if (fm_cnt == 2) begin fr_busy = 1'b1; fm_cnt = 0; end
                end
            end
            if (fr_read_en) rd_total++;
            if (fr_buffer_ready) ready_total++;
            if ((fr_read_en != (src_rd != '0)) ||
                (src_rd != '0 && (!grant_valid || int'(src_rd) != (1 << grant_id))))
                excl_err++;
            if ($countones(src_ack) > 1) excl_err++;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_rd[i]) begin
                    if (fr_data != pat(i, pos[i])) data_err++;
                    pos[i]++;
                end
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_ack[i] && acnt < LOG_N) begin
                    ack_id[acnt]  = i;
                    ack_err[acnt] = int'(src_err);
                    ack_cyc[acnt] = cyc;
                    acnt++;
                    served[i]++;
                end
            end
            if (grant_valid && !prev_gv && gcnt < LOG_N) begin
                glog[gcnt] = int'(grant_id);
                gcyc[gcnt] = cyc;
                gcnt++;
            end
            if (fr_buffer_empt && !prev_empt) empt_cyc = cyc;
        end
        prev_gv   = grant_valid;
        prev_empt = fr_buffer_empt;
    end

    int errors, checks;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_acks(input int target, input int bound);
        int n = 0;
        while (acnt < target && n < bound) begin step(1); n++; end
        check("ack_arrived", int'(acnt >= target), 1);
    endtask

    task automatic wait_reads(input int target, input int bound);
        int n = 0;
        while (rd_total < target && n < bound) begin step(1); n++; end
        check("stream_started", int'(rd_total >= target), 1);
    endtask

    function automatic int outs_or();
        return int'(|{src_rd, src_ack, src_err, fr_buffer_ready, fr_read_en,
                      fr_data, fr_buffer_empt, grant_valid, grant_id});
    endfunction

    typedef struct {
        int src;
        int len;
        bit fr_ok;
        int exp_err;
        int exp_reads;
        int exp_ready;
        bit chk_to;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int abase, rbase, ybase, dbase, gbase;

        tbl[0] = '{src: 0, len: 60,   fr_ok: 1, exp_err: 0, exp_reads: 60,   exp_ready: 1, chk_to: 0};
        tbl[1] = '{src: 2, len: 0,    fr_ok: 1, exp_err: 1, exp_reads: 0,    exp_ready: 0, chk_to: 0};
        tbl[2] = '{src: 2, len: 1501, fr_ok: 1, exp_err: 1, exp_reads: 0,    exp_ready: 0, chk_to: 0};
        tbl[3] = '{src: 1, len: 1,    fr_ok: 1, exp_err: 0, exp_reads: 1,    exp_ready: 1, chk_to: 0};
        tbl[4] = '{src: 2, len: 46,   fr_ok: 0, exp_err: 1, exp_reads: 46,   exp_ready: 1, chk_to: 1};
        tbl[5] = '{src: 3, len: 1500, fr_ok: 1, exp_err: 0, exp_reads: 1500, exp_ready: 1, chk_to: 0};

        errors = 0; checks = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            want[i] = 0; served[i] = 0; pos[i] = 0; len_cfg[i] = '0;
        end
        fm_enable = 1'b1;
        tx_enable = 1'b1;
        rst       = 1'b1;
        step(3);
        check("reset_outputs", outs_or(), 0);
        rst = 1'b0;
        step(2);
        check("idle_outputs", outs_or(), 0);

        // All four sources request two frames each: strict rotation from source 0.
        for (int i = 0; i < NUM_SRC; i++) len_cfg[i] = 11'd46;
        abase = acnt; gbase = gcnt; dbase = data_err;
        for (int i = 0; i < NUM_SRC; i++) want[i] += 2;
        wait_acks(abase + 8, 5000);
        for (int k = 0; k < 8; k++) check("rr_order", glog[gbase + k], k % NUM_SRC);
        check("ifg_gap", gcyc[gbase + 1] - ack_cyc[abase], IFG_CYCLES + 2);
        check("rr_data", data_err - dbase, 0);

        // Single-frame table: valid, bad length, and framer timeout cases.
        for (int r = 0; r < 6; r++) begin
            abase = acnt; rbase = rd_total; ybase = ready_total; dbase = data_err;
            fm_enable = tbl[r].fr_ok;
            len_cfg[tbl[r].src] = LEN_W'(tbl[r].len);
            want[tbl[r].src]++;
            wait_acks(abase + 1, 3000);
            check("row_ack_id",  ack_id[abase],        tbl[r].src);
            check("row_ack_err", ack_err[abase],       tbl[r].exp_err);
            check("row_reads",   rd_total - rbase,     tbl[r].exp_reads);
            check("row_ready",   ready_total - ybase,  tbl[r].exp_ready);
            check("row_data",    data_err - dbase,     0);
            if (tbl[r].chk_to)
                check("timeout_delay", ack_cyc[abase] - empt_cyc, BUSY_TIMEOUT);
        end
        fm_enable = 1'b1;

        // tx_enable drops mid-stream: frame finishes, no further grant until re-enabled.
        len_cfg[1] = 11'd100;
        len_cfg[3] = 11'd46;
        abase = acnt; rbase = rd_total; gbase = gcnt;
        want[1]++;
        wait_reads(rbase + 10, 500);
        tx_enable = 1'b0;
        want[3]++;
        wait_acks(abase + 1, 2000);
        check("txen_ack_id",  ack_id[abase],    1);
        check("txen_ack_err", ack_err[abase],   0);
        check("txen_reads",   rd_total - rbase, 100);
        step(100);
        check("txen_no_grant", gcnt - gbase, 1);
        tx_enable = 1'b1;
        wait_acks(abase + 2, 2000);
        check("txen_resume_id", ack_id[abase + 1], 3);

        // Reset mid-stream: outputs clear at once, then source 0 wins over source 3.
        len_cfg[0] = 11'd200;
        rbase = rd_total;
        want[0]++;
        wait_reads(rbase + 20, 500);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", outs_or(), 0);
        want[3]++;
        step(2);
        abase = acnt; gbase = gcnt;
        rst = 1'b0;
        wait_acks(abase + 2, 3000);
        check("post_reset_first", glog[gbase], 0);
        check("post_reset_ack0",  ack_id[abase], 0);
        check("post_reset_ack1",  ack_id[abase + 1], 3);
        check("post_reset_err",   ack_err[abase] + ack_err[abase + 1], 0);

        check("mutual_exclusion", excl_err, 0);
        check("data_total", data_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
